// File: rtl/sev_seg_scan_ctrl.sv
// Seven-segment scan controller: walks a digit index through the display with
// a blanking gap before each digit and a programmable per-digit dwell time.
module sev_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DIV_W        = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd49999,
  parameter int unsigned BLANK_CYCLES = 4,
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    cfg_we,
  input  logic [DIV_W-1:0]        cfg_div,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam int unsigned BLK_W = $clog2(BLANK_CYCLES + 1);

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_DRIVE} state_t;

  state_t                  state_q;
  logic                    en_q;
  logic [IDX_W-1:0]        idx_q;
  logic [BLK_W-1:0]        blank_cnt;
  logic [DIV_W-1:0]        dwell_cnt;
  logic [DIV_W-1:0]        div_q;
  logic [DIV_W-1:0]        shadow_div;
  logic [NUM_DIGITS-1:0]   an_n_q;
  logic [6:0]              seg_n_q;
  logic                    dp_n_q;
  logic                    fd_q;

  logic [3:0]              nib_sel;
  logic                    blank_last;
  logic                    idx_last;
  logic                    drive_entry;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign nib_sel     = digits[4*idx_q +: 4];
  assign blank_last  = (blank_cnt == BLK_W'(BLANK_CYCLES - 1));
  assign idx_last    = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign drive_entry = enable && (state_q == S_BLANK) && blank_last;

  // The dwell length is frozen at DRIVE entry so a divider write never
  // stretches or cuts the digit currently lit.
  always_ff @(posedge clk) begin
    if (drive_entry) shadow_div <= cfg_we ? cfg_div : div_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_OFF;
      en_q      <= 1'b0;
      idx_q     <= '0;
      blank_cnt <= '0;
      dwell_cnt <= '0;
      div_q     <= DEFAULT_DIV;
      an_n_q    <= '1;
      seg_n_q   <= 7'h7F;
      dp_n_q    <= 1'b1;
      fd_q      <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      en_q <= enable;
      if (cfg_we) div_q <= cfg_div;
      if (!enable) begin
        state_q   <= S_OFF;
        idx_q     <= '0;
        blank_cnt <= '0;
        dwell_cnt <= '0;
        an_n_q    <= '1;
        seg_n_q   <= 7'h7F;
        dp_n_q    <= 1'b1;
      end else begin
        case (state_q)
          S_OFF: begin
            if (en_q) begin
              state_q   <= S_BLANK;
              blank_cnt <= '0;
            end
          end
          S_BLANK: begin
            if (blank_last) begin
              state_q   <= S_DRIVE;
              blank_cnt <= '0;
              dwell_cnt <= '0;
              seg_n_q   <= hex_to_seg(nib_sel);
              dp_n_q    <= ~dp[idx_q];
              an_n_q    <= digit_mask[idx_q] ? ~(NUM_DIGITS'(1) << idx_q) : '1;
            end else begin
              blank_cnt <= blank_cnt + 1'b1;
            end
          end
          S_DRIVE: begin
            if (dwell_cnt == shadow_div) begin
              state_q   <= S_BLANK;
              dwell_cnt <= '0;
              an_n_q    <= '1;
              idx_q     <= idx_last ? '0 : idx_q + 1'b1;
              fd_q      <= idx_last;
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
          default: state_q <= S_OFF;
        endcase
      end
    end
  end

  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Directed bench for sev_seg_scan_ctrl with 4 digits, 2 blank cycles and a
// default divider of 3 (6-cycle slot, 24-cycle frame).
module tb_sev_seg_scan_ctrl;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic        cfg_we;
  logic [15:0] cfg_div;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  digit_mask;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  logic [6:0] hexseg [16];
  logic [3:0] exp3   [35];
  logic [3:0] exp_an;
  logic       exp_dp;
  int         d;
  int         ph;

  sev_seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .DIV_W       (16),
    .DEFAULT_DIV (16'd3),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .cfg_we    (cfg_we),
    .cfg_div   (cfg_div),
    .digits    (digits),
    .dp        (dp),
    .digit_mask(digit_mask),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .dp_n      (dp_n),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step after the first BLANK edge (slot cycle 0), div=3.
  task automatic restart();
    enable  = 1'b0;
    cfg_we  = 1'b1;
    cfg_div = 16'd3;
    tick(1);
    cfg_we = 1'b0;
    enable = 1'b1;
    tick(2);
  endtask

  initial begin
    hexseg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    exp3 = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD, 4'hD,
             4'hD, 4'hD, 4'hF, 4'hF, 4'hB, 4'hF, 4'hF, 4'h7, 4'hF, 4'hF,
             4'hE, 4'hF, 4'hF, 4'hD, 4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hF,
             4'hF, 4'h7, 4'h7, 4'h7, 4'hF};

    resetn     = 1'b0;
    enable     = 1'b0;
    cfg_we     = 1'b0;
    cfg_div    = 16'd0;
    digits     = 16'h3210;
    dp         = 4'b0000;
    digit_mask = 4'hF;

    #12;
    chk("rst_an", an_n, 4'hF);
    chk("rst_seg", seg_n, 7'h7F);
    chk("rst_dp", dp_n, 1'b1);
    chk("rst_idx", digit_idx, 2'd0);
    chk("rst_fd", frame_done, 1'b0);
    #1 resetn = 1'b1;

    // Plain scan of 0,1,2,3 over two frames.
    restart();
    for (int c = 0; c <= 48; c++) begin
      d  = (c / 6) % 4;
      ph = c % 6;
      exp_an = (ph < 2) ? 4'hF : ~(4'b0001 << d);
      chk("scan_an", an_n, exp_an);
      chk("scan_idx", digit_idx, d);
      chk("scan_fd", frame_done, (c == 24 || c == 48));
      if (ph >= 2) chk("scan_seg", seg_n, hexseg[d]);
      tick(1);
    end

    // Masked digits keep their slot; dp on digit 1.
    digit_mask = 4'b1010;
    dp         = 4'b0010;
    restart();
    for (int c = 0; c <= 24; c++) begin
      d  = (c / 6) % 4;
      ph = c % 6;
      exp_an = (ph < 2 || !digit_mask[d]) ? 4'hF : ~(4'b0001 << d);
      exp_dp = ~dp[d];
      chk("mask_an", an_n, exp_an);
      chk("mask_fd", frame_done, (c == 24));
      if (ph >= 2) begin
        chk("mask_seg", seg_n, hexseg[d]);
        chk("mask_dp", dp_n, exp_dp);
      end
      tick(1);
    end
    digit_mask = 4'hF;
    dp         = 4'b0000;

    // Divider write mid-DRIVE, then a write on the DRIVE-entry cycle.
    restart();
    for (int c = 0; c <= 34; c++) begin
      chk("div_an", an_n, exp3[c]);
      chk("div_fd", frame_done, (c == 18 || c == 34));
      if (c == 9)  begin cfg_we = 1'b1; cfg_div = 16'd0; end
      if (c == 10) cfg_we = 1'b0;
      if (c == 25) begin cfg_we = 1'b1; cfg_div = 16'd2; end
      if (c == 26) cfg_we = 1'b0;
      tick(1);
    end

    // Enable drop during digit 2's DRIVE, then re-enable.
    restart();
    tick(15);
    chk("drop_pre_an", an_n, 4'hB);
    enable = 1'b0;
    tick(1);
    chk("drop_an", an_n, 4'hF);
    chk("drop_seg", seg_n, 7'h7F);
    chk("drop_dp", dp_n, 1'b1);
    chk("drop_idx", digit_idx, 2'd0);
    chk("drop_fd", frame_done, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("drop_quiet_fd", frame_done, 1'b0);
      chk("drop_quiet_an", an_n, 4'hF);
    end
    enable = 1'b1;
    tick(2);
    chk("reen_blank_an", an_n, 4'hF);
    chk("reen_idx", digit_idx, 2'd0);
    tick(2);
    chk("reen_an", an_n, 4'hE);
    chk("reen_seg", seg_n, 7'h40);

    // Digit data changes during digit 0's DRIVE.
    restart();
    tick(3);
    chk("tear_seg_c3", seg_n, 7'h40);
    digits = 16'h3218;
    tick(1);
    chk("tear_seg_c4", seg_n, 7'h40);
    chk("tear_an_c4", an_n, 4'hE);
    tick(1);
    chk("tear_seg_c5", seg_n, 7'h40);
    tick(21);
    chk("tear_next_seg", seg_n, 7'h00);
    chk("tear_next_an", an_n, 4'hE);
    digits = 16'h3210;

    // Asynchronous reset mid-DRIVE restores the default divider.
    restart();
    tick(2);
    chk("areset_pre_an", an_n, 4'hE);
    cfg_we  = 1'b1;
    cfg_div = 16'd7;
    tick(1);
    cfg_we = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("areset_an", an_n, 4'hF);
    chk("areset_seg", seg_n, 7'h7F);
    chk("areset_dp", dp_n, 1'b1);
    chk("areset_idx", digit_idx, 2'd0);
    chk("areset_fd", frame_done, 1'b0);
    #1 resetn = 1'b1;
    tick(2);
    chk("arel_blank_an", an_n, 4'hF);
    tick(5);
    chk("arel_drive_last_an", an_n, 4'hE);
    tick(1);
    chk("arel_exit_an", an_n, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sev_seg_scan_ctrl.md
# sev_seg_scan_ctrl

Time-multiplexing scan controller for the SoC seven-segment display. It divides the system clock into per-digit dwell periods and steps a digit index through all digits. For each digit it captures that digit's nibble and decimal point, hex-decodes them and drives one active-low anode with a blanking gap between digits to prevent ghosting. It sits between the memory-mapped display registers (digit data, mask, enable, divider) and the board pins.

## Interface

- NUM_DIGITS, 8: number of digits scanned; must be at least 2.
- DIV_W, 16: width of the dwell divider.
- DEFAULT_DIV, 16'd49999: divider reset value; each digit is driven for div+1 cycles.
- BLANK_CYCLES, 4: anodes-off cycles before each digit; must be at least 1.

Ports:

- clk  in  1  system clock.
- resetn  in  1  reset; asynchronous, active-low.
- enable  in  1  1 = scanning; 0 = display dark.
- cfg_we  in  1  one-cycle write strobe for cfg_div.
- cfg_div  in  DIV_W  new dwell divider value.
- digits  in  4*NUM_DIGITS  digit i nibble at [4i+3:4i].
- dp  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- digit_mask  in  NUM_DIGITS  1 = digit shown; 0 = slot kept but anode stays off.
- an_n  out  NUM_DIGITS  anodes, active-low, at most one low.
- seg_n  out  7  segments, active-low; bit 0 = a … bit 6 = g.
- dp_n  out  1  decimal point, active-low.
- digit_idx  out  $clog2(NUM_DIGITS)  index of the current or next digit.
- frame_done  out  1  one-cycle pulse per completed frame.

## Operation

- All outputs are registered.
- Reset values:
  - State OFF.
  - an_n all 1, seg_n 7'h7F, dp_n 1.
  - digit_idx 0, frame_done 0.
  - div register DEFAULT_DIV; dwell counter 0; blank counter 0.
- FSM states:
  - OFF: outputs dark, digit_idx held at 0. Moves to BLANK when enable=1.
  - BLANK: an_n all 1. Lasts exactly BLANK_CYCLES cycles.
    - On the transition into DRIVE the block captures digits[digit_idx], dp[digit_idx] and digit_mask[digit_idx], and latches the current div into a shadow register.
  - DRIVE: seg_n and dp_n come from the captured nibble and dp. an_n[digit_idx]=0 if the captured mask bit is 1, otherwise an_n stays all 1. Lasts shadow_div+1 cycles.
    - On exit, digit_idx increments modulo NUM_DIGITS and the FSM returns to BLANK.
    - If digit_idx was NUM_DIGITS-1, frame_done=1 for one cycle, coincident with the first BLANK cycle of digit 0.
- enable=0 in any state: next cycle goes to OFF with outputs dark, digit_idx=0 and counters cleared. Any partial frame is abandoned with no frame_done.
- cfg_we=1 writes the div register immediately, but the new value takes effect only at the next DRIVE entry. The current dwell is never truncated or extended.
- cfg_we on the same cycle as a DRIVE entry: the newly written value is used for that DRIVE.
- Changes to digits, dp or digit_mask during DRIVE do not affect the display until that digit's next slot (no tearing).
- Hex decode to seg_n (hex, g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- div=0 is legal: DRIVE lasts 1 cycle.
- The dwell counter is DIV_W bits and compares with == shadow_div, so it never wraps past the terminal value.

## Timing

- enable sampled 1 at edge k: BLANK is entered at edge k+1, and the first DRIVE starts at edge k+1+BLANK_CYCLES.
- Digit slot = BLANK_CYCLES + shadow_div + 1 cycles.
- Frame = NUM_DIGITS × slot when div is constant.
- During DRIVE, seg_n/dp_n/an_n change together on the DRIVE-entry edge. an_n returns to all 1 on the DRIVE-exit edge.
- Segments may change only while an_n is all 1, except on the DRIVE-entry edge itself.
- Reset asserted mid-DRIVE: outputs go to reset values immediately, without waiting for a clock edge.
- After reset release, OFF is held for at least one cycle before BLANK is entered.

## Test plan

All scenarios use NUM_DIGITS=4, BLANK_CYCLES=2, DEFAULT_DIV=3.

- Reset then enable=1, digits=16'h3210, mask=4'hF:
  - an_n sequence 1111×2, 1110×4, 1111×2, 1101×4, …
  - seg_n during each DRIVE: 40, 79, 24, 30.
  - frame_done pulses once every 24 cycles.
- Mask and dp, with mask=4'b1010, dp=4'b0010:
  - digits 0 and 2 keep an_n=1111 across their full slots, so frame timing is unchanged.
  - digit 1 shows dp_n=0.
- Divider write: cfg_we with cfg_div=0 in the middle of digit 1's DRIVE.
  - Digit 1 still lasts 4 cycles; digit 2 onward lasts 1 cycle, giving a 3-cycle slot.
  - Also cover cfg_we on the exact DRIVE-entry cycle, which applies to that same digit.
- enable drops during digit 2's DRIVE:
  - next cycle: an_n=1111, seg_n=7F, digit_idx=0, no frame_done.
  - re-enable: restarts at digit 0 after 2 BLANK cycles.
- Data change mid-DRIVE: digits[3:0] changes 0→8 on DRIVE cycle 2 of digit 0.
  - seg_n stays 40 for the rest of that slot.
  - the next frame's digit 0 shows 00.
- Asynchronous reset pulse between clock edges during DRIVE:
  - all outputs go to reset values before the next edge.
  - div returns to 3 after release.
